// File: rtl/eater_display_if.sv
// Output-register bus between the cpu-side driver and the eater_display panel.
// The master drives the load strobe and data. The slave drives the display and status signals.
interface eater_display_if;
  logic       out_load;
  logic [7:0] out_data;
  logic       signed_mode;
  logic [6:0] seg;
  logic [3:0] dig_en;
  logic       busy;
  logic       done;

  modport master (
    output out_load, out_data, signed_mode,
    input  seg, dig_en, busy, done
  );

  modport slave (
    input  out_load, out_data, signed_mode,
    output seg, dig_en, busy, done
  );
endinterface

// File: rtl/eater_display.sv
// Latches the cpu output register and converts it to BCD with a sequential double-dabble.
// Drives a multiplexed 4-digit common-cathode 7-segment panel showing sign, hundreds, tens and ones.
module eater_display #(
  parameter int SCAN_DIV = 4
) (
  input logic             clk,
  input logic             clr,
  eater_display_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [19:0] r_shift;
  logic        r_neg;
  logic [11:0] r_shown;
  logic        r_shown_neg;
  logic        r_done;
  logic [15:0] r_presc;
  logic [1:0]  r_idx;
  logic [3:0]  r_dig;
  logic [6:0]  r_seg;

  logic [7:0]  w_mag;
  logic        w_commit;
  logic        w_wrap;
  logic [1:0]  w_idx_nxt;
  logic [11:0] w_shown_nxt;
  logic        w_neg_nxt;
  logic [6:0]  w_seg_nxt;

  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[8+4*k +: 4] >= 4'd5) t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // 8'h80 in signed mode negates back to 8'h80, which is exactly 128 unsigned.
  assign w_mag    = (bus.signed_mode & bus.out_data[7]) ? (~bus.out_data + 8'd1) : bus.out_data;
  assign w_commit = (r_state == S_COMMIT) && !bus.out_load;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_done      <= 1'b0;
      r_shown     <= 12'd0;
      r_shown_neg <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.out_load) begin
        r_state <= S_CONV;
        r_cnt   <= 3'd0;
      end else begin
        case (r_state)
          S_CONV: begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= S_COMMIT;
          end
          S_COMMIT: begin
            r_shown     <= r_shift[19:8];
            r_shown_neg <= r_neg;
            r_done      <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.out_load) begin
      r_shift <= {12'd0, w_mag};
      r_neg   <= bus.signed_mode & bus.out_data[7];
    end else if (r_state == S_CONV) begin
      r_shift <= dabble(r_shift);
    end
  end

  // Scan side: glyph is computed from next-cycle index and shown value so seg and dig_en never skew.
  assign w_wrap      = (r_presc == 16'(SCAN_DIV - 1));
  assign w_idx_nxt   = w_wrap ? r_idx + 2'd1 : r_idx;
  assign w_shown_nxt = w_commit ? r_shift[19:8] : r_shown;
  assign w_neg_nxt   = w_commit ? r_neg : r_shown_neg;

  always_comb begin
    w_seg_nxt = 7'b0000000;
    case (w_idx_nxt)
      2'd0: w_seg_nxt = seg7(w_shown_nxt[3:0]);
      2'd1: if (w_shown_nxt[11:4] != 8'd0) w_seg_nxt = seg7(w_shown_nxt[7:4]);
      2'd2: if (w_shown_nxt[11:8] != 4'd0) w_seg_nxt = seg7(w_shown_nxt[11:8]);
      default: w_seg_nxt = w_neg_nxt ? 7'b1000000 : 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_presc <= 16'd0;
      r_idx   <= 2'd0;
      r_dig   <= 4'b0001;
      r_seg   <= 7'b0111111;
    end else begin
      r_presc <= w_wrap ? 16'd0 : r_presc + 16'd1;
      r_idx   <= w_idx_nxt;
      r_dig   <= 4'b0001 << w_idx_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  assign bus.seg    = r_seg;
  assign bus.dig_en = r_dig;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;

endmodule
